// File: rtl/instr_decode_top.sv
// instr_decode_top: RV32I decode stage that also acts as the ID/EX pipeline register.
// Every output is registered, so results appear one cycle after instr/pc/jalr_ra/stall.
// A stall turns the registered instruction into a bubble by clearing its side-effect
// controls, while the rest of the decode still flows through.
// Optional build macro: ID_ILLEGAL_DETECT_EN adds a registered 'illegal' flag output.

module instr_decode_top #(
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] jalr_ra,
    input  logic            stall,
    output logic [PC_W-1:0] dest_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [31:0]     imm32_final,
    output logic            reg_we,
    output logic            mem_we,
    output logic            mem_re,
    output logic            branch,
    output logic            mem_to_reg,
    output logic            alu_src,
    output logic [6:0]      ALU_control,
    output logic [2:0]      mem_read_type,
`ifdef ID_ILLEGAL_DETECT_EN
    output logic            illegal,
`endif
    output logic [1:0]      mem_store_type
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_isR;
    logic            w_isIAlu;
    logic            w_isLoad;
    logic            w_isStore;
    logic            w_isBranch;
    logic            w_isLui;
    logic            w_isAuipc;
    logic            w_isJal;
    logic            w_isJalr;
    logic            w_isKnown;
    logic            w_isShiftImm;
    logic [31:0]     w_imm;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic            w_regWe;
    logic            w_aluSrc;
    logic            w_branch;
    logic            w_f7b;
    logic [2:0]      w_aluFunct3;
    logic [2:0]      w_cls;
    logic [PC_W-1:0] w_jalrSum;
    logic [PC_W-1:0] w_destPc;

    logic [PC_W-1:0] r_destPc;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [31:0]     r_imm;
    logic            r_regWe;
    logic            r_memWe;
    logic            r_memRe;
    logic            r_branch;
    logic            r_memToReg;
    logic            r_aluSrc;
    logic [6:0]      r_aluControl;
    logic [2:0]      r_memReadType;
    logic [1:0]      r_memStoreType;

    assign w_opcode   = instr[6:0];
    assign w_funct3   = instr[14:12];

    assign w_isR      = (w_opcode == OP_R);
    assign w_isIAlu   = (w_opcode == OP_IALU);
    assign w_isLoad   = (w_opcode == OP_LOAD);
    assign w_isStore  = (w_opcode == OP_STORE);
    assign w_isBranch = (w_opcode == OP_BRANCH);
    assign w_isLui    = (w_opcode == OP_LUI);
    assign w_isAuipc  = (w_opcode == OP_AUIPC);
    assign w_isJal    = (w_opcode == OP_JAL);
    assign w_isJalr   = (w_opcode == OP_JALR);
    assign w_isKnown  = w_isR | w_isIAlu | w_isLoad | w_isStore | w_isBranch |
                        w_isLui | w_isAuipc | w_isJal | w_isJalr;

    // Shift-immediates carry a 5-bit shamt, not a signed 12-bit immediate.
    assign w_isShiftImm = w_isIAlu & ((w_funct3 == 3'b001) | (w_funct3 == 3'b101));

    // Pick the immediate layout for the instruction format; R-type and unknown give zero.
    always_comb begin
        w_imm = 32'd0;
        case (w_opcode)
            OP_IALU: begin
                if (w_isShiftImm) begin
                    w_imm = {27'd0, instr[24:20]};
                end else begin
                    w_imm = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OP_LOAD, OP_JALR: w_imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:         w_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:        w_imm = {{19{instr[31]}}, instr[31], instr[7],
                                       instr[30:25], instr[11:8], 1'b0};
            OP_JAL:           w_imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                       instr[20], instr[30:21], 1'b0};
            OP_LUI, OP_AUIPC: w_imm = {instr[31:12], 12'd0};
            default:          w_imm = 32'd0;
        endcase
    end

    assign w_rs1 = (w_isR | w_isIAlu | w_isLoad | w_isStore | w_isBranch | w_isJalr)
                   ? instr[19:15] : 5'd0;
    assign w_rs2 = (w_isR | w_isStore | w_isBranch) ? instr[24:20] : 5'd0;
    assign w_rd  = (w_isR | w_isIAlu | w_isLoad | w_isLui | w_isAuipc | w_isJal | w_isJalr)
                   ? instr[11:7] : 5'd0;

    assign w_regWe  = w_isR | w_isIAlu | w_isLoad | w_isLui | w_isAuipc | w_isJal | w_isJalr;
    assign w_branch = w_isBranch | w_isJal | w_isJalr;
    assign w_aluSrc = w_isKnown & ~w_isR & ~w_isBranch;

    // instr[30] only selects SUB/SRA/SRAI, so it is passed on just for those encodings.
    assign w_f7b       = instr[30] & (w_isR | (w_isIAlu & (w_funct3 == 3'b101)));
    assign w_aluFunct3 = (w_isR | w_isIAlu | w_isBranch) ? w_funct3 : 3'b000;

    // Map the opcode to the ALU class field; unknown opcodes fall to zero.
    always_comb begin
        w_cls = 3'b000;
        case (w_opcode)
            OP_IALU:         w_cls = 3'b001;
            OP_LOAD:         w_cls = 3'b010;
            OP_STORE:        w_cls = 3'b011;
            OP_BRANCH:       w_cls = 3'b100;
            OP_LUI:          w_cls = 3'b101;
            OP_AUIPC:        w_cls = 3'b110;
            OP_JAL, OP_JALR: w_cls = 3'b111;
            default:         w_cls = 3'b000;
        endcase
    end

    assign w_jalrSum = jalr_ra + w_imm[PC_W-1:0];

    // Control-transfer target, wrapping at the PC width; everything else falls through.
    always_comb begin
        w_destPc = pc + PC_W'(4);
        if (w_isBranch || w_isJal) begin
            w_destPc = pc + w_imm[PC_W-1:0];
        end else if (w_isJalr) begin
            w_destPc = w_jalrSum & ~PC_W'(1);
        end
    end

    // ID/EX register: reset clears all, stall squashes only the side-effect controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_destPc       <= '0;
            r_rs1          <= 5'd0;
            r_rs2          <= 5'd0;
            r_rd           <= 5'd0;
            r_imm          <= 32'd0;
            r_regWe        <= 1'b0;
            r_memWe        <= 1'b0;
            r_memRe        <= 1'b0;
            r_branch       <= 1'b0;
            r_memToReg     <= 1'b0;
            r_aluSrc       <= 1'b0;
            r_aluControl   <= 7'd0;
            r_memReadType  <= 3'd0;
            r_memStoreType <= 2'd0;
        end else begin
            r_destPc       <= w_destPc;
            r_rs1          <= w_rs1;
            r_rs2          <= w_rs2;
            r_rd           <= w_rd;
            r_imm          <= w_imm;
            r_regWe        <= w_regWe & ~stall;
            r_memWe        <= w_isStore & ~stall;
            r_memRe        <= w_isLoad & ~stall;
            r_branch       <= w_branch & ~stall;
            r_memToReg     <= w_isLoad & ~stall;
            r_aluSrc       <= w_aluSrc;
            r_aluControl   <= {w_f7b, w_aluFunct3, w_cls};
            r_memReadType  <= w_isLoad ? w_funct3 : 3'd0;
            r_memStoreType <= w_isStore ? w_funct3[1:0] : 2'd0;
        end
    end

    assign dest_pc        = r_destPc;
    assign rs1            = r_rs1;
    assign rs2            = r_rs2;
    assign rd             = r_rd;
    assign imm32_final    = r_imm;
    assign reg_we         = r_regWe;
    assign mem_we         = r_memWe;
    assign mem_re         = r_memRe;
    assign branch         = r_branch;
    assign mem_to_reg     = r_memToReg;
    assign alu_src        = r_aluSrc;
    assign ALU_control    = r_aluControl;
    assign mem_read_type  = r_memReadType;
    assign mem_store_type = r_memStoreType;

`ifdef ID_ILLEGAL_DETECT_EN
    logic [6:0] w_funct7;
    logic       w_illegal;
    logic       r_illegal;

    assign w_funct7 = instr[31:25];

    // Flag encodings outside RV32I: unknown opcode, bad funct7, reserved branch funct3.
    always_comb begin
        w_illegal = 1'b0;
        if (!w_isKnown) begin
            w_illegal = 1'b1;
        end else if (w_isR) begin
            w_illegal = !((w_funct7 == 7'b0000000) ||
                          ((w_funct7 == 7'b0100000) &&
                           ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
        end else if (w_isIAlu && (w_funct3 == 3'b001)) begin
            w_illegal = (w_funct7 != 7'b0000000);
        end else if (w_isIAlu && (w_funct3 == 3'b101)) begin
            w_illegal = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
        end else if (w_isBranch) begin
            w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
        end
    end

    // The illegal flag is a property of the encoding, so a stall does not hide it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_illegal;
        end
    end

    assign illegal = r_illegal;
`endif

endmodule

// File: tb/tb_instr_decode_top.sv
// tb_instr_decode_top: directed-vector bench for instr_decode_top.
// A behavioural decoder model predicts every registered output each cycle, and
// hand-computed literal checks pin the model on the key cases.

module tb_instr_decode_top;

    localparam int PC_W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] instr;
    logic [15:0] pc;
    logic [15:0] jalr_ra;

    logic [15:0] dest_pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm32_final;
    logic        reg_we;
    logic        mem_we;
    logic        mem_re;
    logic        branch;
    logic        mem_to_reg;
    logic        alu_src;
    logic [6:0]  ALU_control;
    logic [2:0]  mem_read_type;
    logic [1:0]  mem_store_type;
    logic        illegalSig;

    int nVectors = 0;
    int nMiscompares = 0;

    typedef struct packed {
        logic [15:0] destPc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        regWe;
        logic        memWe;
        logic        memRe;
        logic        branch;
        logic        memToReg;
        logic        aluSrc;
        logic [6:0]  alu;
        logic [2:0]  rdType;
        logic [1:0]  stType;
        logic        illegal;
    } outT;

    outT actual;
    outT expQ;
    outT lit;
    bit  expValid = 1'b0;

    instr_decode_top #(.PC_W(PC_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr          (instr),
        .pc             (pc),
        .jalr_ra        (jalr_ra),
        .stall          (stall),
        .dest_pc        (dest_pc),
        .rs1            (rs1),
        .rs2            (rs2),
        .rd             (rd),
        .imm32_final    (imm32_final),
        .reg_we         (reg_we),
        .mem_we         (mem_we),
        .mem_re         (mem_re),
        .branch         (branch),
        .mem_to_reg     (mem_to_reg),
        .alu_src        (alu_src),
        .ALU_control    (ALU_control),
        .mem_read_type  (mem_read_type),
`ifdef ID_ILLEGAL_DETECT_EN
        .illegal        (illegalSig),
`endif
        .mem_store_type (mem_store_type)
    );

`ifndef ID_ILLEGAL_DETECT_EN
    assign illegalSig = 1'b0;
`endif

    always #5 clk = ~clk;

    // Gather the DUT outputs into one record so they compare as a unit.
    always_comb begin
        actual.destPc   = dest_pc;
        actual.rs1      = rs1;
        actual.rs2      = rs2;
        actual.rd       = rd;
        actual.imm      = imm32_final;
        actual.regWe    = reg_we;
        actual.memWe    = mem_we;
        actual.memRe    = mem_re;
        actual.branch   = branch;
        actual.memToReg = mem_to_reg;
        actual.aluSrc   = alu_src;
        actual.alu      = ALU_control;
        actual.rdType   = mem_read_type;
        actual.stType   = mem_store_type;
        actual.illegal  = illegalSig;
    end

    // Reference decoder: one row of outputs per instruction class, immediates built arithmetically.
    function automatic outT model(input logic [31:0] ins, input logic [15:0] p,
                                  input logic [15:0] ra, input logic st);
        outT o;
        int immI, immS, immB, immJ;
        logic [2:0] f3;
        logic [6:0] f7;
        o    = '0;
        f3   = ins[14:12];
        f7   = ins[31:25];
        immI = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
        immS = int'({ins[31:25], ins[11:7]}) - (ins[31] ? 4096 : 0);
        immB = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
               + int'(ins[11:8]) * 2;
        immJ = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
               + int'(ins[30:21]) * 2;
        o.destPc = p + 16'd4;
        case (ins[6:0])
            7'b0110011: begin
                o.rs1 = ins[19:15]; o.rs2 = ins[24:20]; o.rd = ins[11:7];
                o.regWe = 1'b1;
                o.alu = {ins[30], f3, 3'd0};
                o.illegal = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
            end
            7'b0010011: begin
                o.rs1 = ins[19:15]; o.rd = ins[11:7];
                o.regWe = 1'b1; o.aluSrc = 1'b1;
                if ((f3 == 3'd1) || (f3 == 3'd5)) begin
                    o.imm = int'(ins[24:20]);
                    o.illegal = (f3 == 3'd1) ? (f7 != 7'h00) : !((f7 == 7'h00) || (f7 == 7'h20));
                end else begin
                    o.imm = immI;
                end
                o.alu = {(f3 == 3'd5) & ins[30], f3, 3'd1};
            end
            7'b0000011: begin
                o.rs1 = ins[19:15]; o.rd = ins[11:7]; o.imm = immI;
                o.regWe = 1'b1; o.memRe = 1'b1; o.memToReg = 1'b1; o.aluSrc = 1'b1;
                o.rdType = f3; o.alu = 7'd2;
            end
            7'b0100011: begin
                o.rs1 = ins[19:15]; o.rs2 = ins[24:20]; o.imm = immS;
                o.memWe = 1'b1; o.aluSrc = 1'b1;
                o.stType = f3[1:0]; o.alu = 7'd3;
            end
            7'b1100011: begin
                o.rs1 = ins[19:15]; o.rs2 = ins[24:20]; o.imm = immB;
                o.branch = 1'b1; o.alu = {1'b0, f3, 3'd4};
                o.destPc = 16'(int'(p) + immB);
                o.illegal = (f3 == 3'd2) || (f3 == 3'd3);
            end
            7'b0110111: begin
                o.rd = ins[11:7]; o.imm = ins & 32'hFFFFF000;
                o.regWe = 1'b1; o.aluSrc = 1'b1; o.alu = 7'd5;
            end
            7'b0010111: begin
                o.rd = ins[11:7]; o.imm = ins & 32'hFFFFF000;
                o.regWe = 1'b1; o.aluSrc = 1'b1; o.alu = 7'd6;
            end
            7'b1101111: begin
                o.rd = ins[11:7]; o.imm = immJ;
                o.regWe = 1'b1; o.branch = 1'b1; o.aluSrc = 1'b1; o.alu = 7'd7;
                o.destPc = 16'(int'(p) + immJ);
            end
            7'b1100111: begin
                o.rs1 = ins[19:15]; o.rd = ins[11:7]; o.imm = immI;
                o.regWe = 1'b1; o.branch = 1'b1; o.aluSrc = 1'b1; o.alu = 7'd7;
                o.destPc = 16'(int'(ra) + immI) & 16'hFFFE;
            end
            default: o.illegal = 1'b1;
        endcase
`ifndef ID_ILLEGAL_DETECT_EN
        o.illegal = 1'b0;
`endif
        if (st) begin
            o.regWe = 1'b0; o.memWe = 1'b0; o.memRe = 1'b0;
            o.branch = 1'b0; o.memToReg = 1'b0;
        end
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one vector after the falling edge; return just after the capturing rising edge.
    task automatic applyStimulus(input logic r, input logic s, input logic [31:0] i,
                                 input logic [15:0] p, input logic [15:0] ra);
        @(negedge clk);
        rst     = r;
        stall   = s;
        instr   = i;
        pc      = p;
        jalr_ra = ra;
        @(posedge clk);
        #1;
    endtask

    // Predict what the DUT registers at each rising edge from the inputs it sees there.
    always @(posedge clk) begin
        expQ     = rst ? outT'('0) : model(instr, pc, jalr_ra, stall);
        expValid = 1'b1;
    end

    // Compare the whole output record against the prediction on every falling edge.
    always @(negedge clk) begin
        if (expValid) checkOutput("pipeline", 128'(actual), 128'(expQ));
    end

    initial begin
        rst = 1'b1; stall = 1'b0; instr = 32'h015a04b3; pc = 16'h0000; jalr_ra = 16'h0000;
        $display("[TB] starting instr_decode_top directed vectors");

        applyStimulus(1'b1, 1'b0, 32'h015a04b3, 16'h0000, 16'h0000);
        applyStimulus(1'b1, 1'b0, 32'h015a04b3, 16'h0000, 16'h0000);
        checkOutput("reset_zero", 128'(actual), 128'(0));

        applyStimulus(1'b0, 1'b0, 32'h015a04b3, 16'h0000, 16'h0000);
        checkOutput("add_fields", 128'({rs1, rs2, rd, reg_we, alu_src, ALU_control}),
                    128'({5'd20, 5'd21, 5'd9, 1'b1, 1'b0, 7'b0000000}));

        applyStimulus(1'b0, 1'b0, 32'h40a48433, 16'h0004, 16'h0000);
        checkOutput("sub_alu", 128'({ALU_control, rd}), 128'({7'b1000000, 5'd8}));

        applyStimulus(1'b0, 1'b0, 32'h00d675b3, 16'h0008, 16'h0000);
        checkOutput("and_alu", 128'(ALU_control), 128'(7'b0111000));

        applyStimulus(1'b0, 1'b0, 32'h00952823, 16'h000c, 16'h0000);
        checkOutput("sw_fields",
                    128'({rs1, rs2, rd, imm32_final, mem_we, mem_store_type, reg_we}),
                    128'({5'd10, 5'd9, 5'd0, 32'h00000010, 1'b1, 2'b10, 1'b0}));

        applyStimulus(1'b0, 1'b0, 32'h00530623, 16'h0010, 16'h0000);
        checkOutput("sb_type", 128'({mem_we, mem_store_type}), 128'({1'b1, 2'b00}));

        applyStimulus(1'b0, 1'b0, 32'h00835283, 16'h0014, 16'h0000);
        checkOutput("lhu_fields",
                    128'({mem_re, mem_to_reg, reg_we, alu_src, mem_read_type, imm32_final, rs2}),
                    128'({1'b1, 1'b1, 1'b1, 1'b1, 3'b101, 32'd8, 5'd0}));

        applyStimulus(1'b0, 1'b0, 32'hfe839ce3, 16'h0100, 16'h0000);
        checkOutput("bne_target", 128'({imm32_final, dest_pc, branch, ALU_control}),
                    128'({32'hfffffff8, 16'h00f8, 1'b1, 7'b0001100}));

        applyStimulus(1'b0, 1'b0, 32'h00628863, 16'h0000, 16'h0000);
        checkOutput("beq_target", 128'(dest_pc), 128'(16'h0010));

        applyStimulus(1'b0, 1'b1, 32'h01042383, 16'h0020, 16'h0000);
        checkOutput("lw_stalled",
                    128'({reg_we, mem_re, mem_to_reg, alu_src, rd, imm32_final, mem_read_type}),
                    128'({1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'd16, 3'b010}));

        applyStimulus(1'b0, 1'b1, 32'h020000ef, 16'h0000, 16'h0000);
        checkOutput("jal_stalled", 128'({branch, reg_we, dest_pc}), 128'({1'b0, 1'b0, 16'h0020}));

        applyStimulus(1'b0, 1'b0, 32'h005100e7, 16'h0040, 16'h1000);
        checkOutput("jalr_target",
                    128'({dest_pc, rd, rs1, rs2, branch, reg_we, ALU_control}),
                    128'({16'h1004, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 7'b0000111}));

        applyStimulus(1'b0, 1'b0, 32'h020000ef, 16'hfff0, 16'h0000);
        checkOutput("jal_wrap", 128'({dest_pc, imm32_final, rs1, rd}),
                    128'({16'h0010, 32'h00000020, 5'd0, 5'd1}));

        applyStimulus(1'b0, 1'b0, 32'h123452b7, 16'h0050, 16'h0000);
        checkOutput("lui_fields", 128'({imm32_final, rs1, rd, alu_src, ALU_control}),
                    128'({32'h12345000, 5'd0, 5'd5, 1'b1, 7'b0000101}));

        applyStimulus(1'b0, 1'b0, 32'hfffff517, 16'h0200, 16'h0000);
        checkOutput("auipc_fields", 128'({imm32_final, rd, ALU_control, dest_pc}),
                    128'({32'hfffff000, 5'd10, 7'b0000110, 16'h0204}));

        applyStimulus(1'b0, 1'b0, 32'h40725193, 16'h0060, 16'h0000);
        checkOutput("srai_fields", 128'({imm32_final, ALU_control, rs1, rd}),
                    128'({32'd7, 7'b1101001, 5'd4, 5'd3}));

        applyStimulus(1'b0, 1'b0, 32'hfff00093, 16'h0064, 16'h0000);
        checkOutput("addi_neg", 128'({imm32_final, ALU_control}), 128'({32'hffffffff, 7'b0000001}));

        applyStimulus(1'b0, 1'b0, 32'hffffffff, 16'h1234, 16'h0000);
        lit = '0;
        lit.destPc = 16'h1238;
`ifdef ID_ILLEGAL_DETECT_EN
        lit.illegal = 1'b1;
`endif
        checkOutput("unknown_op", 128'(actual), 128'(lit));

        applyStimulus(1'b1, 1'b1, 32'h015a04b3, 16'h0070, 16'h0000);
        checkOutput("midstream_reset", 128'(actual), 128'(0));

        applyStimulus(1'b0, 1'b0, 32'h01f11093, 16'h0074, 16'h0000);
        checkOutput("slli_shamt", 128'({imm32_final, ALU_control}), 128'({32'd31, 7'b0001001}));

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/instr_decode_top.md
Name: instr_decode_top

Overview:
RV32I instruction-decode stage with registered outputs, forming the ID/EX pipeline register. It decodes a 32-bit instruction into:
- register indices;
- a sign-extended immediate;
- memory, register-file and ALU control;
- a 16-bit control-transfer target.

It sits between the IF/ID register and the execute stage. `stall` injects a bubble.

Parameters:
- PC_W, 16, width of pc, jalr_ra and dest_pc.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr  in  32  instruction word
- pc  in  PC_W  address of instr
- jalr_ra  in  PC_W  rs1 operand value used as JALR base
- stall  in  1  hazard stall; forces bubble
- dest_pc  out  PC_W  target/next address
- rs1, rs2, rd  out  5 each  register indices (0 when unused by format)
- imm32_final  out  32  sign-extended immediate
- reg_we, mem_we, mem_re, branch, mem_to_reg, alu_src  out  1 each  control
- ALU_control  out  7  ALU operation code
- mem_read_type  out  3  load funct3
- mem_store_type  out  2  store size

Behaviour:
- Clocking and latency:
  - All outputs are registered; latency is exactly 1 cycle from instr/pc/jalr_ra/stall to outputs.
  - rst=1 at an edge clears every output to 0, overriding stall. Reset is effective mid-stream.
- Opcode classes:
  - R 0110011
  - I-ALU 0010011
  - LOAD 0000011
  - STORE 0100011
  - BRANCH 1100011
  - LUI 0110111
  - AUIPC 0010111
  - JAL 1101111
  - JALR 1100111
- Immediates (standard RV32I, sign-extended from instr[31]):
  - I for I-ALU/LOAD/JALR; S for STORE; B for BRANCH; J for JAL; U (instr[31:12]<<12) for LUI/AUIPC.
  - R-type and illegal opcodes yield imm32_final=0.
  - SLLI/SRLI/SRAI imm = zero-extended shamt instr[24:20].
- Index zeroing:
  - rs1=0 for LUI/AUIPC/JAL.
  - rs2=0 unless R/STORE/BRANCH.
  - rd=0 for STORE/BRANCH.
- Control signals:
  - reg_we=1: R, I-ALU, LOAD, LUI, AUIPC, JAL, JALR.
  - mem_re=1, mem_to_reg=1: LOAD only.
  - mem_we=1: STORE only.
  - branch=1: BRANCH, JAL, JALR.
  - alu_src=1: every class except R and BRANCH.
- Memory size fields:
  - mem_read_type = instr[14:12] for LOAD, else 000.
  - mem_store_type = instr[13:12] for STORE (00 byte, 01 half, 10 word), else 00.
- ALU_control = {f7b, funct3, cls}:
  - f7b = instr[30] for R-type and for I-ALU funct3=101; else 0.
  - funct3 = instr[14:12] for R/I-ALU/BRANCH; 000 otherwise.
  - cls: 000 R, 001 I-ALU, 010 LOAD, 011 STORE, 100 BRANCH, 101 LUI, 110 AUIPC, 111 JAL/JALR.
- dest_pc (arithmetic mod 2^PC_W, imm truncated to PC_W):
  - BRANCH/JAL: pc+imm.
  - JALR: (jalr_ra+imm) with bit0 cleared.
  - Otherwise: pc+4.
- Stall: stall=1 registers reg_we, mem_we, mem_re, branch and mem_to_reg as 0. All other fields decode normally.
- Unrecognised opcode: every output 0 except dest_pc=pc+4.

Optional Feature:
- Macro ID_ILLEGAL_DETECT_EN.
- Defined:
  - Adds output port `illegal` (1 bit), registered.
  - `illegal` is set for unknown opcodes, for bad funct7 on R/shift-immediate, and for funct3 values 010/011 on BRANCH.
  - `illegal` is cleared by rst and is not masked by stall.
- Undefined: the port is absent and decode behaviour is unchanged.

Test Plan:
- rst=1 for 2 cycles with instr=015a04b3 -> all outputs 0; release -> next cycle rs1=20, rs2=21, rd=9, reg_we=1, alu_src=0, ALU_control=0000000.
- instr=40a48433 (sub x8,x9,x10) -> ALU_control=1000000, rd=8; instr=00d675b3 (and) -> ALU_control=0111000.
- instr=00952823 (sw x9,16(x10)) -> rs1=10, rs2=9, rd=0, imm=00000010, mem_we=1, mem_store_type=10, reg_we=0; instr=00530623 (sb) -> store_type=00.
- instr=00835283 (lhu x5,8(x6)) -> mem_re=1, mem_to_reg=1, reg_we=1, alu_src=1, mem_read_type=101, imm=8, rs2=0.
- Branches:
  - pc=0x0100, instr=fe839ce3 (bne x7,x8,-8) -> imm=fffffff8, dest_pc=0x00F8, branch=1, ALU_control=0001100.
  - instr=00628863 (beq) at pc=0 -> dest_pc=0x0010.
- stall=1 with instr=01042383 (lw) -> reg_we, mem_re, mem_to_reg all 0; rd=7, imm=16, mem_read_type=010 still decoded.
